// File: rtl/tcp_out_arbiter.sv
// tcp_out_arbiter: packet-granular echo/LASP arbiter onto the 10G output stream.
// Rev 1.0 - echo priority, LASP starvation guard, registered output slice.
`default_nettype none

module tcp_out_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 16
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic [63:0]      EchoTData,
  input  logic [7:0]       EchoTKeep,
  input  logic             EchoTLast,
  input  logic             EchoTValid,
  output logic             EchoTReady,
  input  logic [63:0]      LaspTData,
  input  logic [7:0]       LaspTKeep,
  input  logic             LaspTLast,
  input  logic             LaspTValid,
  output logic             LaspTReady,
  output logic [63:0]      OutTData,
  output logic [7:0]       OutTKeep,
  output logic             OutTLast,
  output logic             OutTValid,
  input  logic             OutTReady,
  input  logic             LaspEnable,
  output logic [CNT_W-1:0] EchoFrames,
  output logic [CNT_W-1:0] LaspFrames,
  output logic             Busy
);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    GRANT_ECHO = 2'd1,
    GRANT_LASP = 2'd2
  } state_t;

  localparam logic [7:0] STARVE_LIM8 = 8'(STARVE_LIMIT);

  state_t      state;
  logic [7:0]  starve;
  logic        can_load;
  logic        sel_valid;
  logic [63:0] sel_data;
  logic [7:0]  sel_keep;
  logic        sel_last;
  logic        load;
  logic        lasp_req;
  logic        force_lasp;

  always_comb begin
    sel_valid = 1'b0;
    sel_data  = EchoTData;
    sel_keep  = EchoTKeep;
    sel_last  = EchoTLast;
    case (state)
      GRANT_ECHO: sel_valid = EchoTValid;
      GRANT_LASP: begin
        sel_valid = LaspTValid;
        sel_data  = LaspTData;
        sel_keep  = LaspTKeep;
        sel_last  = LaspTLast;
      end
      default: sel_valid = 1'b0;
    endcase
  end

  // The output slice can accept a beat when empty or draining this cycle.
  assign can_load   = !OutTValid || OutTReady;
  assign load       = sel_valid && can_load;
  assign EchoTReady = (state == GRANT_ECHO) && can_load;
  assign LaspTReady = (state == GRANT_LASP) && can_load;
  assign Busy       = (state != IDLE);

  assign lasp_req   = LaspEnable && LaspTValid;
  assign force_lasp = lasp_req && (starve >= STARVE_LIM8);

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state      <= IDLE;
      starve     <= 8'd0;
      OutTValid  <= 1'b0;
      OutTData   <= 64'd0;
      OutTKeep   <= 8'd0;
      OutTLast   <= 1'b0;
      EchoFrames <= '0;
      LaspFrames <= '0;
    end else begin
      if (load) begin
        OutTData  <= sel_data;
        OutTKeep  <= sel_keep;
        OutTLast  <= sel_last;
        OutTValid <= 1'b1;
      end else if (OutTReady) begin
        OutTValid <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (force_lasp) begin
            state  <= GRANT_LASP;
            starve <= 8'd0;
          end else if (EchoTValid) begin
            state <= GRANT_ECHO;
            // Count echo grants that made a waiting LASP frame wait longer.
            if (lasp_req && (starve != 8'hFF)) begin
              starve <= starve + 8'd1;
            end else if (!LaspTValid) begin
              starve <= 8'd0;
            end
          end else if (lasp_req) begin
            state  <= GRANT_LASP;
            starve <= 8'd0;
          end else if (!LaspTValid) begin
            starve <= 8'd0;
          end
        end
        GRANT_ECHO: begin
          if (load && EchoTLast) begin
            state      <= IDLE;
            EchoFrames <= EchoFrames + CNT_W'(1);
          end
        end
        GRANT_LASP: begin
          if (load && LaspTLast) begin
            state      <= IDLE;
            LaspFrames <= LaspFrames + CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_tcp_out_arbiter.sv
// tb_tcp_out_arbiter: vector table, hand-written corner cases and a randomized
// frame-level scoreboard for tcp_out_arbiter.
`default_nettype none

module tb_tcp_out_arbiter;

  localparam int STARVE_LIMIT = 4;
  localparam int CNT_W        = 4;
  localparam int CNT_MOD      = 1 << CNT_W;

  logic             Clock = 1'b0;
  logic             Reset;
  logic [63:0]      EchoTData;
  logic [7:0]       EchoTKeep;
  logic             EchoTLast;
  logic             EchoTValid;
  logic             EchoTReady;
  logic [63:0]      LaspTData;
  logic [7:0]       LaspTKeep;
  logic             LaspTLast;
  logic             LaspTValid;
  logic             LaspTReady;
  logic [63:0]      OutTData;
  logic [7:0]       OutTKeep;
  logic             OutTLast;
  logic             OutTValid;
  logic             OutTReady;
  logic             LaspEnable;
  logic [CNT_W-1:0] EchoFrames;
  logic [CNT_W-1:0] LaspFrames;
  logic             Busy;

  always #5 Clock = ~Clock;

  tcp_out_arbiter #(.STARVE_LIMIT(STARVE_LIMIT), .CNT_W(CNT_W)) dut (
    .Clock(Clock), .Reset(Reset),
    .EchoTData(EchoTData), .EchoTKeep(EchoTKeep), .EchoTLast(EchoTLast),
    .EchoTValid(EchoTValid), .EchoTReady(EchoTReady),
    .LaspTData(LaspTData), .LaspTKeep(LaspTKeep), .LaspTLast(LaspTLast),
    .LaspTValid(LaspTValid), .LaspTReady(LaspTReady),
    .OutTData(OutTData), .OutTKeep(OutTKeep), .OutTLast(OutTLast),
    .OutTValid(OutTValid), .OutTReady(OutTReady),
    .LaspEnable(LaspEnable), .EchoFrames(EchoFrames), .LaspFrames(LaspFrames),
    .Busy(Busy)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        ev;
    logic [63:0] ed;
    logic        el;
    logic        lv;
    logic [63:0] ld;
    logic        ll;
    logic        len;
    logic        ordy;
    logic        ov;
    logic [63:0] od;
    logic        ol;
    logic        er;
    logic        lr;
    logic        busy;
    logic [3:0]  ef;
    logic [3:0]  lf;
  } vec_t;

  function automatic vec_t mkv(input logic ev, input logic [63:0] ed, input logic el,
                               input logic lv, input logic [63:0] ld, input logic ll,
                               input logic len, input logic ordy,
                               input logic ov, input logic [63:0] od, input logic ol,
                               input logic er, input logic lr, input logic busy,
                               input logic [3:0] ef, input logic [3:0] lf);
    vec_t v;
    v.ev = ev; v.ed = ed; v.el = el; v.lv = lv; v.ld = ld; v.ll = ll;
    v.len = len; v.ordy = ordy; v.ov = ov; v.od = od; v.ol = ol;
    v.er = er; v.lr = lr; v.busy = busy; v.ef = ef; v.lf = lf;
    return v;
  endfunction

  // Scoreboard state: driver-side and output-side positions per source.
  int e_f, e_b, l_f, l_b;
  bit e_v, l_v;
  int e_cnt, l_cnt;
  int oe_f, oe_b, ol_f, ol_b;
  bit o_in;
  int o_src;
  int order[$];
  int fixed_len_g;

  function automatic int flen(input int src, input int f);
    if (fixed_len_g > 0) return fixed_len_g;
    return 1 + ((f * 5 + src * 3 + f / 3) % 4);
  endfunction

  function automatic logic [63:0] mkd(input int src, input int f, input int b);
    return {(src == 0) ? 8'hEC : 8'h1A, 8'h00, 16'(f), 16'(b), 8'h00, 8'(f * 7 + b + src)};
  endfunction

  task automatic idle_inputs();
    EchoTValid = 1'b0; EchoTData = '0; EchoTKeep = '0; EchoTLast = 1'b0;
    LaspTValid = 1'b0; LaspTData = '0; LaspTKeep = '0; LaspTLast = 1'b0;
    OutTReady  = 1'b1; LaspEnable = 1'b1;
  endtask

  task automatic start_phase(input int fl);
    @(negedge Clock);
    Reset = 1'b0;
    idle_inputs();
    @(negedge Clock);
    @(negedge Clock);
    Reset = 1'b1;
    e_f = 0; e_b = 0; l_f = 0; l_b = 0; e_v = 0; l_v = 0;
    e_cnt = 0; l_cnt = 0; oe_f = 0; oe_b = 0; ol_f = 0; ol_b = 0;
    o_in = 0; o_src = 0; order.delete(); fixed_len_g = fl;
  endtask

  // en_mode: 0 LASP disabled, 1 enabled, 2 randomly toggled.
  task automatic run_phase(input int cycles, input int pe, input int pl, input int pr,
                           input int en_mode, input int max_e, input int max_l);
    for (int c = 0; c < cycles; c++) begin
      int src, ef, eb;
      logic [63:0] xd;
      @(negedge Clock);
      check("echo_frames", 64'(EchoFrames), 64'(e_cnt % CNT_MOD));
      check("lasp_frames", 64'(LaspFrames), 64'(l_cnt % CNT_MOD));
      if (e_b == 0 && l_b == 0 && !e_v && !l_v && e_f >= max_e && l_f >= max_l && !OutTValid)
        break;

      if (!e_v && (e_b > 0 || e_f < max_e) && $urandom_range(99) < pe) e_v = 1;
      if (!l_v && (l_b > 0 || l_f < max_l) && $urandom_range(99) < pl) l_v = 1;
      EchoTValid = e_v;
      EchoTData  = e_v ? mkd(0, e_f, e_b) : 64'd0;
      EchoTKeep  = EchoTData[7:0];
      EchoTLast  = e_v && (e_b == flen(0, e_f) - 1);
      LaspTValid = l_v;
      LaspTData  = l_v ? mkd(1, l_f, l_b) : 64'd0;
      LaspTKeep  = LaspTData[7:0];
      LaspTLast  = l_v && (l_b == flen(1, l_f) - 1);
      OutTReady  = ($urandom_range(99) < pr);
      if (en_mode == 2) begin
        if ($urandom_range(9) == 0) LaspEnable = ~LaspEnable;
      end else begin
        LaspEnable = (en_mode == 1);
      end
      #1;

      check("ready_excl", 64'(EchoTReady && LaspTReady), 64'd0);
      check("ready_stall", 64'(OutTValid && !OutTReady && (EchoTReady || LaspTReady)), 64'd0);
      if (en_mode == 0) check("lasp_disabled", 64'(LaspTReady), 64'd0);

      if (OutTValid && OutTReady) begin
        src = (OutTData[63:56] == 8'hEC) ? 0 : (OutTData[63:56] == 8'h1A) ? 1 : 2;
        if (src == 2) begin
          check("out_tag", 64'(OutTData[63:56]), 64'hEC);
        end else begin
          if (o_in) check("no_interleave", 64'(src), 64'(o_src));
          ef = (src == 0) ? oe_f : ol_f;
          eb = (src == 0) ? oe_b : ol_b;
          xd = mkd(src, ef, eb);
          check("out_data", OutTData, xd);
          check("out_keep", 64'(OutTKeep), 64'(xd[7:0]));
          check("out_last", 64'(OutTLast), 64'(eb == flen(src, ef) - 1));
          if (eb == flen(src, ef) - 1) begin
            if (src == 0) begin oe_f++; oe_b = 0; end else begin ol_f++; ol_b = 0; end
            o_in = 0;
            order.push_back(src);
          end else begin
            if (src == 0) oe_b++; else ol_b++;
            o_in = 1;
            o_src = src;
          end
        end
      end

      if (e_v && EchoTReady) begin
        if (EchoTLast) begin e_cnt++; e_f++; e_b = 0; end else e_b++;
        e_v = 0;
      end
      if (l_v && LaspTReady) begin
        if (LaspTLast) begin l_cnt++; l_f++; l_b = 0; end else l_b++;
        l_v = 0;
      end
    end
  endtask

  task automatic drain();
    run_phase(400, 100, 100, 100, 1,
              e_f + ((e_v || e_b > 0) ? 1 : 0), l_f + ((l_v || l_b > 0) ? 1 : 0));
    check("drain_echo", 64'(oe_f), 64'(e_f));
    check("drain_lasp", 64'(ol_f), 64'(l_f));
    check("drain_idle", 64'(Busy), 64'd0);
  endtask

  localparam logic [63:0] A0 = 64'hEC00_0000_0000_00A0;
  localparam logic [63:0] A1 = 64'hEC00_0000_0000_00A1;
  localparam logic [63:0] A2 = 64'hEC00_0000_0000_00A2;
  localparam logic [63:0] B0 = 64'h1A00_0000_0000_00B0;
  localparam logic [63:0] B1 = 64'h1A00_0000_0000_00B1;
  localparam logic [63:0] B2 = 64'h1A00_0000_0000_00B2;
  localparam logic [63:0] B3 = 64'h1A00_0000_0000_00B3;
  localparam logic [63:0] C0 = 64'hEC00_0000_0000_00C0;
  localparam logic [63:0] D0 = 64'hEC00_0000_0000_00D0;

  vec_t vecs[15];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //                 ev ed  el lv ld  ll len rdy ov od  ol er lr bz ef lf
    vecs[0]  = mkv(1, A0, 0, 0, 0,  0, 0, 1,  0, 0,  0, 0, 0, 0, 0, 0);
    vecs[1]  = mkv(1, A0, 0, 0, 0,  0, 0, 1,  0, 0,  0, 1, 0, 1, 0, 0);
    vecs[2]  = mkv(1, A1, 0, 0, 0,  0, 0, 1,  1, A0, 0, 1, 0, 1, 0, 0);
    vecs[3]  = mkv(1, A2, 1, 0, 0,  0, 0, 1,  1, A1, 0, 1, 0, 1, 0, 0);
    vecs[4]  = mkv(0, 0,  0, 0, 0,  0, 0, 1,  1, A2, 1, 0, 0, 0, 1, 0);
    vecs[5]  = mkv(0, 0,  0, 0, 0,  0, 1, 1,  0, 0,  0, 0, 0, 0, 1, 0);
    vecs[6]  = mkv(0, 0,  0, 1, B0, 0, 1, 1,  0, 0,  0, 0, 0, 0, 1, 0);
    vecs[7]  = mkv(0, 0,  0, 1, B0, 0, 1, 1,  0, 0,  0, 0, 1, 1, 1, 0);
    vecs[8]  = mkv(0, 0,  0, 1, B1, 0, 1, 1,  1, B0, 0, 0, 1, 1, 1, 0);
    vecs[9]  = mkv(0, 0,  0, 1, B2, 0, 1, 0,  1, B1, 0, 0, 0, 1, 1, 0);
    vecs[10] = mkv(0, 0,  0, 1, B2, 0, 1, 0,  1, B1, 0, 0, 0, 1, 1, 0);
    vecs[11] = mkv(0, 0,  0, 1, B2, 0, 1, 1,  1, B1, 0, 0, 1, 1, 1, 0);
    vecs[12] = mkv(0, 0,  0, 1, B3, 1, 1, 1,  1, B2, 0, 0, 1, 1, 1, 0);
    vecs[13] = mkv(0, 0,  0, 0, 0,  0, 1, 1,  1, B3, 1, 0, 0, 0, 1, 1);
    vecs[14] = mkv(0, 0,  0, 0, 0,  0, 1, 1,  0, 0,  0, 0, 0, 0, 1, 1);

    Reset = 1'b0;
    idle_inputs();
    repeat (3) @(negedge Clock);
    check("rst_out_valid", 64'(OutTValid), 64'd0);
    check("rst_out_data", OutTData, 64'd0);
    check("rst_out_last", 64'(OutTLast), 64'd0);
    check("rst_echo_ready", 64'(EchoTReady), 64'd0);
    check("rst_lasp_ready", 64'(LaspTReady), 64'd0);
    check("rst_busy", 64'(Busy), 64'd0);
    check("rst_echo_frames", 64'(EchoFrames), 64'd0);
    Reset = 1'b1;

    for (int i = 0; i < 15; i++) begin
      @(negedge Clock);
      EchoTValid = vecs[i].ev; EchoTData = vecs[i].ed; EchoTKeep = vecs[i].ed[7:0];
      EchoTLast  = vecs[i].el;
      LaspTValid = vecs[i].lv; LaspTData = vecs[i].ld; LaspTKeep = vecs[i].ld[7:0];
      LaspTLast  = vecs[i].ll;
      LaspEnable = vecs[i].len; OutTReady = vecs[i].ordy;
      #1;
      check($sformatf("vec%0d_valid", i), 64'(OutTValid), 64'(vecs[i].ov));
      if (vecs[i].ov) begin
        check($sformatf("vec%0d_data", i), OutTData, vecs[i].od);
        check($sformatf("vec%0d_keep", i), 64'(OutTKeep), 64'(vecs[i].od[7:0]));
        check($sformatf("vec%0d_last", i), 64'(OutTLast), 64'(vecs[i].ol));
      end
      check($sformatf("vec%0d_echo_ready", i), 64'(EchoTReady), 64'(vecs[i].er));
      check($sformatf("vec%0d_lasp_ready", i), 64'(LaspTReady), 64'(vecs[i].lr));
      check($sformatf("vec%0d_busy", i), 64'(Busy), 64'(vecs[i].busy));
      check($sformatf("vec%0d_echo_frames", i), 64'(EchoFrames), 64'(vecs[i].ef));
      check($sformatf("vec%0d_lasp_frames", i), 64'(LaspFrames), 64'(vecs[i].lf));
    end

    // Reset in the middle of an echo frame, then a fresh one-beat frame.
    @(negedge Clock);
    idle_inputs();
    EchoTValid = 1'b1; EchoTData = C0; EchoTKeep = C0[7:0];
    @(negedge Clock);
    #1 check("mid_grant", 64'(EchoTReady), 64'd1);
    @(negedge Clock);
    EchoTData = C0 + 64'd1; EchoTKeep = EchoTData[7:0];
    @(negedge Clock);
    EchoTData = C0 + 64'd2; EchoTKeep = EchoTData[7:0];
    Reset = 1'b0;
    @(negedge Clock);
    Reset = 1'b1;
    EchoTValid = 1'b0;
    #1;
    check("mid_rst_valid", 64'(OutTValid), 64'd0);
    check("mid_rst_busy", 64'(Busy), 64'd0);
    check("mid_rst_echo_frames", 64'(EchoFrames), 64'd0);
    check("mid_rst_lasp_frames", 64'(LaspFrames), 64'd0);
    check("mid_rst_ready", 64'(EchoTReady), 64'd0);
    @(negedge Clock);
    EchoTValid = 1'b1; EchoTData = D0; EchoTKeep = D0[7:0]; EchoTLast = 1'b1;
    @(negedge Clock);
    #1 check("post_rst_grant", 64'(EchoTReady), 64'd1);
    @(negedge Clock);
    EchoTValid = 1'b0; EchoTLast = 1'b0;
    #1;
    check("post_rst_valid", 64'(OutTValid), 64'd1);
    check("post_rst_data", OutTData, D0);
    check("post_rst_last", 64'(OutTLast), 64'd1);
    @(negedge Clock);
    check("post_rst_frames", 64'(EchoFrames), 64'd1);
    check("post_rst_drained", 64'(OutTValid), 64'd0);

    // Both sources saturated with 2-beat frames: E,E,E,E,L repeating.
    start_phase(2);
    run_phase(60, 100, 100, 100, 1, 100000, 100000);
    check("starve_frame_count", 64'(order.size() >= 15), 64'd1);
    for (int i = 0; i < 15 && i < order.size(); i++)
      check($sformatf("starve_order%0d", i), 64'(order[i]), 64'((i % 5 == 4) ? 1 : 0));
    drain();

    // LASP disabled while it keeps requesting.
    start_phase(0);
    run_phase(120, 60, 100, 80, 0, 100000, 100000);
    check("lasp_off_frames", 64'(LaspFrames), 64'd0);
    check("lasp_off_echo_flow", 64'(e_cnt > 3), 64'd1);
    drain();

    // Counter wrap: 17 single-beat echo frames on a 4-bit counter.
    start_phase(1);
    run_phase(200, 100, 0, 100, 1, 17, 0);
    check("wrap_count", 64'(e_cnt), 64'd17);
    check("wrap_echo_frames", 64'(EchoFrames), 64'd1);

    // Randomized traffic, backpressure and LaspEnable toggling.
    start_phase(0);
    run_phase(3000, 50, 50, 70, 2, 100000, 100000);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/tcp_out_arbiter.md
Name: tcp_out_arbiter

Overview:
Packet-granular arbiter feeding the network 10Gbps output stream. Shares the output between two 64-bit AXI-Stream sources: echo responses from the TCP/IP processor datapath, and LASP data. Echo has priority, with a starvation guard for LASP. Registered output slice; per-source frame counters for status.

Parameters:
STARVE_LIMIT, 4, consecutive echo frames granted while LASP waits before LASP is forced next (1..255)
CNT_W, 16, width of frame counters

Ports:
Clock  in  1  system clock
Reset  in  1  synchronous, active-low reset
EchoTData  in  64  echo source data
EchoTKeep  in  8  echo byte enables
EchoTLast  in  1  echo end of frame
EchoTValid  in  1  echo valid
EchoTReady  out  1  echo ready
LaspTData  in  64  LASP source data
LaspTKeep  in  8  LASP byte enables
LaspTLast  in  1  LASP end of frame
LaspTValid  in  1  LASP valid
LaspTReady  out  1  LASP ready
OutTData  out  64  network output data
OutTKeep  out  8  output byte enables
OutTLast  out  1  output end of frame
OutTValid  out  1  output valid
OutTReady  in  1  downstream ready
LaspEnable  in  1  0: LASP never granted; echo only
EchoFrames  out  CNT_W  echo frames forwarded (tlast beats accepted into output stage)
LaspFrames  out  CNT_W  LASP frames forwarded
Busy  out  1  high while in a GRANT state

Behaviour:
- Reset (Reset==0 at posedge): state IDLE, OutTValid=0, OutTData/Keep/Last=0, EchoTReady=LaspTReady=0, counters=0, starve count=0, Busy=0. Reset mid-frame abandons the frame; no tlast is emitted for it.
- Output stage: one register. load = sel_valid && (!OutTValid || OutTReady). On load, the register takes the selected source beat and OutTValid=1. If OutTValid && OutTReady && !load, OutTValid=0. Latency input→output: 1 cycle. Full throughput: 1 beat/cycle when OutTReady held high.
- Ready: granted source TReady = (!OutTValid || OutTReady); the non-granted source TReady = 0. In IDLE both TReady are 0. TReady is combinational from state and output-register status; it never depends on the source's own TValid.
- FSM states: IDLE, GRANT_ECHO, GRANT_LASP.
  - IDLE: force_lasp = LaspEnable && LaspTValid && starve>=STARVE_LIMIT. If force_lasp → GRANT_LASP; else if EchoTValid → GRANT_ECHO; else if LaspEnable && LaspTValid → GRANT_LASP; else stay. The decision takes 1 cycle: one idle bubble between frames.
  - GRANT_x: beats are forwarded until a beat with TLast is loaded; then → IDLE at the same edge. There is no timeout; a source stalling mid-frame holds the grant.
- Starve counter (8-bit, saturating at 255): on entry to GRANT_ECHO while LaspEnable && LaspTValid, increment. On entry to GRANT_LASP, clear. If LaspTValid==0 in IDLE, clear.
- Counters: the source counter increments when a tlast beat is loaded. Counters wrap modulo 2^CNT_W; there is no saturation.
- LaspEnable deasserted during GRANT_LASP: the current frame completes; the new value applies only at the next IDLE decision.
- Busy = (state != IDLE).
- TKeep is passed through unmodified. No frame checking or drop.

Test Plan:
- Echo only, 3-beat frame with OutTReady=1: output matches the input beats in order with 1-cycle latency; EchoFrames=1; return to IDLE on the cycle after tlast.
- Both sources continuously valid, STARVE_LIMIT=4, frames of 2 beats: output frame sequence is E,E,E,E,L,E,E,E,E,L…; frames are never interleaved.
- OutTReady toggled 1,0,0,1 during a 4-beat LASP frame: no beat lost or duplicated; OutT* stable while stalled; LaspTReady=0 whenever OutTValid && !OutTReady.
- LaspEnable=0 with LaspTValid=1 for 100 cycles: LaspTReady stays 0 and LaspFrames=0; echo frames flow normally.
- Reset asserted low for 1 cycle at beat 2 of a 5-beat echo frame: next cycle OutTValid=0, counters=0, state IDLE; a subsequent frame forwards correctly.
- With CNT_W=4, 17 echo frames: EchoFrames=1 (wrap).
